// File: rtl/vga_video_pkg.sv
// Shared definitions for the VGA video generator: 640x480@60 timing, pattern codes
// and the colour-bar column decode.
package vga_video_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int BAR_WIDTH = 80;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_MOVE  = 2'd2,
        PAT_BLACK = 2'd3
    } pattern_e;

    // hc/80 as a compare chain against the seven bar edges
    function automatic logic [2:0] bar_index(input logic [9:0] hc);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (hc >= 10'(i * BAR_WIDTH)) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters with visible/sync region decode; reusable by any
// pixel generator that needs the raw (hc,vc) and region flags.
module vga_timing_counter
    import vga_video_pkg::*;
#(
    parameter int C_h_visible = H_VISIBLE,
    parameter int C_h_fp      = H_FP,
    parameter int C_h_sync    = H_SYNC,
    parameter int C_h_bp      = H_BP,
    parameter int C_v_visible = V_VISIBLE,
    parameter int C_v_fp      = V_FP,
    parameter int C_v_sync    = V_SYNC,
    parameter int C_v_bp      = V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       visible,
    output logic       hs_act,
    output logic       vs_act
);

    localparam logic [9:0] H_LAST   = 10'(C_h_visible + C_h_fp + C_h_sync + C_h_bp - 1);
    localparam logic [9:0] V_LAST   = 10'(C_v_visible + C_v_fp + C_v_sync + C_v_bp - 1);
    localparam logic [9:0] H_VIS    = 10'(C_h_visible);
    localparam logic [9:0] V_VIS    = 10'(C_v_visible);
    localparam logic [9:0] HS_START = 10'(C_h_visible + C_h_fp);
    localparam logic [9:0] HS_END   = 10'(C_h_visible + C_h_fp + C_h_sync);
    localparam logic [9:0] VS_START = 10'(C_v_visible + C_v_fp);
    localparam logic [9:0] VS_END   = 10'(C_v_visible + C_v_fp + C_v_sync);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign visible = (hc < H_VIS) && (vc < V_VIS);
    assign hs_act  = (hc >= HS_START) && (hc < HS_END);
    assign vs_act  = (vc >= VS_START) && (vc < VS_END);

endmodule

// File: rtl/vga_video_gen.sv
// VGA timing and test-pattern generator; every output is registered once from
// the same raster position so all outputs share a fixed one-cycle latency.
module vga_video_gen
    import vga_video_pkg::*;
#(
    parameter int   C_depth     = 3,
    parameter int   C_h_visible = H_VISIBLE,
    parameter int   C_h_fp      = H_FP,
    parameter int   C_h_sync    = H_SYNC,
    parameter int   C_h_bp      = H_BP,
    parameter int   C_v_visible = V_VISIBLE,
    parameter int   C_v_fp      = V_FP,
    parameter int   C_v_sync    = V_SYNC,
    parameter int   C_v_bp      = V_BP,
    parameter logic C_sync_pol  = 1'b0
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic [1:0]         pattern,
    output logic [C_depth-1:0] red,
    output logic [C_depth-1:0] green,
    output logic [C_depth-1:0] blue,
    output logic               hsync,
    output logic               vsync,
    output logic               blank,
    output logic               frame_start,
    output logic [9:0]         x,
    output logic [9:0]         y
);

    localparam logic [C_depth-1:0] FULL = '1;

    logic               rst_sync_n;
    logic [9:0]         hc, vc;
    logic               visible, hs_act, vs_act;
    logic               origin_p0;
    pattern_e           pat_q, pat_p0;
    logic [6:0]         bar_pos, bar_p0;
    logic               started;
    logic [2:0]         bar_idx_p0;
    logic [C_depth-1:0] r_p0, g_p0, b_p0;

    // Reset asserts immediately, releases on the clock edge after reset_n rises
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) rst_sync_n <= 1'b0;
        else          rst_sync_n <= 1'b1;
    end

    vga_timing_counter #(
        .C_h_visible(C_h_visible), .C_h_fp(C_h_fp), .C_h_sync(C_h_sync), .C_h_bp(C_h_bp),
        .C_v_visible(C_v_visible), .C_v_fp(C_v_fp), .C_v_sync(C_v_sync), .C_v_bp(C_v_bp)
    ) u_timing (
        .clk    (clk_pixel),
        .rst_n  (rst_sync_n),
        .hc     (hc),
        .vc     (vc),
        .visible(visible),
        .hs_act (hs_act),
        .vs_act (vs_act)
    );

    assign origin_p0  = (hc == 10'd0) && (vc == 10'd0);
    assign bar_idx_p0 = bar_index(hc);

    // Pixel (0,0) already uses the new frame's state, so a frame never mixes two patterns
    always_comb begin
        pat_p0 = pat_q;
        bar_p0 = bar_pos;
        if (origin_p0) begin
            pat_p0 = pattern_e'(pattern);
            bar_p0 = !started ? 7'd0 : (bar_pos == 7'd79) ? 7'd0 : bar_pos + 7'd1;
        end
    end

    always_comb begin
        r_p0 = '0;
        g_p0 = '0;
        b_p0 = '0;
        if (visible) begin
            case (pat_p0)
                PAT_BARS: begin
                    r_p0 = {C_depth{bar_idx_p0[2]}};
                    g_p0 = {C_depth{bar_idx_p0[1]}};
                    b_p0 = {C_depth{bar_idx_p0[0]}};
                end
                PAT_CHECK: begin
                    if (hc[5] ^ vc[5]) begin
                        r_p0 = FULL;
                        g_p0 = FULL;
                        b_p0 = FULL;
                    end
                end
                PAT_MOVE: begin
                    b_p0 = FULL;
                    if (hc[9:3] == bar_p0) begin
                        r_p0 = FULL;
                        g_p0 = FULL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pat_q   <= PAT_BARS;
            bar_pos <= '0;
            started <= 1'b0;
        end else if (origin_p0) begin
            pat_q   <= pat_p0;
            bar_pos <= bar_p0;
            started <= 1'b1;
        end
    end

    // Output register stage
    always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hsync       <= ~C_sync_pol;
            vsync       <= ~C_sync_pol;
            blank       <= 1'b1;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else begin
            red         <= r_p0;
            green       <= g_p0;
            blue        <= b_p0;
            hsync       <= hs_act ? C_sync_pol : ~C_sync_pol;
            vsync       <= vs_act ? C_sync_pol : ~C_sync_pol;
            blank       <= ~visible;
            frame_start <= origin_p0;
            x           <= hc;
            y           <= vc;
        end
    end

endmodule

// File: tb/tb_vga_video_gen.sv
// Bench for vga_video_gen: a full-width/short-height instance and a tiny instance
// (for many frames of the moving bar) checked each cycle against a raster model.
module tb_vga_video_gen;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } vout_t;

    localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVV = 34,  AVF = 1,  AVS = 2,  AVB = 1;
    localparam int AHT = AHV + AHF + AHS + AHB;
    localparam int AVT = AVV + AVF + AVS + AVB;
    localparam int AF  = AHT * AVT;
    localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 2;
    localparam int BVV = 4,  BVF = 1, BVS = 1, BVB = 1;
    localparam int BHT = BHV + BHF + BHS + BHB;
    localparam int BVT = BVV + BVF + BVS + BVB;
    localparam int BF  = BHT * BVT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] pat_a = 2'd0, pat_b = 2'd2;
    logic [2:0] red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic       hsync_a, vsync_a, blank_a, fs_a, hsync_b, vsync_b, blank_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;
    vout_t      oa, ob;

    int         vectors = 0, miscompares = 0;
    int         e = 0;
    logic [1:0] fpat_a = 2'd0, fpat_b = 2'd0;
    int         line_hs = 0, vs_cnt = 0, bl_cnt = 0, per_cnt = 0;
    bit         have_prev = 1'b0;

    always #5 clk = ~clk;

    assign oa = {red_a, green_a, blue_a, hsync_a, vsync_a, blank_a, fs_a, x_a, y_a};
    assign ob = {red_b, green_b, blue_b, hsync_b, vsync_b, blank_b, fs_b, x_b, y_b};

    vga_video_gen #(
        .C_depth(3), .C_h_visible(AHV), .C_h_fp(AHF), .C_h_sync(AHS), .C_h_bp(AHB),
        .C_v_visible(AVV), .C_v_fp(AVF), .C_v_sync(AVS), .C_v_bp(AVB), .C_sync_pol(1'b0)
    ) dut_a (
        .clk_pixel(clk), .reset_n(reset_n), .pattern(pat_a),
        .red(red_a), .green(green_a), .blue(blue_a),
        .hsync(hsync_a), .vsync(vsync_a), .blank(blank_a), .frame_start(fs_a),
        .x(x_a), .y(y_a)
    );

    vga_video_gen #(
        .C_depth(3), .C_h_visible(BHV), .C_h_fp(BHF), .C_h_sync(BHS), .C_h_bp(BHB),
        .C_v_visible(BVV), .C_v_fp(BVF), .C_v_sync(BVS), .C_v_bp(BVB), .C_sync_pol(1'b0)
    ) dut_b (
        .clk_pixel(clk), .reset_n(reset_n), .pattern(pat_b),
        .red(red_b), .green(green_b), .blue(blue_b),
        .hsync(hsync_b), .vsync(vsync_b), .blank(blank_b), .frame_start(fs_b),
        .x(x_b), .y(y_b)
    );

    // Expected outputs ee edges after reset release (ee<2: still reset values)
    function automatic vout_t model(input int hv, input int hf, input int hs, input int hb,
                                    input int vv, input int vf, input int vs, input int vb,
                                    input int ee, input logic [1:0] pat);
        vout_t o;
        int ht, vt, p, h, v, bar, idx;
        bit vis;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        o.bl = 1'b1;
        if (ee < 2) return o;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        p   = ee - 2;
        h   = p % ht;
        v   = (p / ht) % vt;
        bar = (p / (ht * vt)) % 80;
        vis = (h < hv) && (v < vv);
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.bl = !vis;
        o.hs = !(h >= hv + hf && h < hv + hf + hs);
        o.vs = !(v >= vv + vf && v < vv + vf + vs);
        o.fs = (h == 0) && (v == 0);
        if (vis) begin
            case (pat)
                2'd0: begin
                    idx = h / 80;
                    o.r = ((idx / 4) % 2 == 1) ? 3'd7 : 3'd0;
                    o.g = ((idx / 2) % 2 == 1) ? 3'd7 : 3'd0;
                    o.b = (idx % 2 == 1)       ? 3'd7 : 3'd0;
                end
                2'd1: if ((h / 32) % 2 != (v / 32) % 2) {o.r, o.g, o.b} = 9'h1FF;
                2'd2: begin
                    o.b = 3'd7;
                    if (h / 8 == bar) {o.r, o.g} = 6'h3F;
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    task automatic chk(input string tag, input vout_t obs, input vout_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s e=%0d observed=%h required=%h", tag, e, obs, exp);
        end
    endtask

    task automatic ichk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s e=%0d observed=%0d required=%0d", tag, e, obs, exp);
        end
    endtask

    task automatic cycle();
        int p, h, v, fr;
        @(posedge clk);
        #1;
        if (reset_n) e++;
        if (e >= 2 && (e - 2) % AF == 0) fpat_a = pat_a;
        if (e >= 2 && (e - 2) % BF == 0) fpat_b = pat_b;
        chk("a_pixel", oa, model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, e, fpat_a));
        chk("b_pixel", ob, model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, e, fpat_b));
        if (e == 1) ichk("a_no_fs_first_edge", int'(fs_a), 0);
        if (e == 2) ichk("a_first_fs_xy", int'({fs_a, x_a, y_a}), 1 << 20);
        if (e >= 2) begin
            p  = e - 2;
            h  = p % AHT;
            v  = (p / AHT) % AVT;
            fr = p / AF;
            if (fr == 0 && v == 25 && h == 80) ichk("a_bars_after_switch", int'({red_a, green_a, blue_a}), 9'o007);
            if (fr == 1 && v == 0 && h == 31)  ichk("a_check_31_0", int'({red_a, green_a, blue_a}), 0);
            if (fr == 1 && v == 0 && h == 32)  ichk("a_check_32_0", int'({red_a, green_a, blue_a}), 9'o777);
            if (fr == 1 && v == 32 && h == 32) ichk("a_check_32_32", int'({red_a, green_a, blue_a}), 0);
            if ((e - 2) == 80 * BF) ichk("b_bar_wrapped", int'({red_b, green_b, blue_b}), 9'o777);
            if (p % AF == 0 && p > 0) begin
                ichk("a_vsync_low_cycles", vs_cnt, AVS * AHT);
                ichk("a_visible_cycles", bl_cnt, AHV * AVV);
                vs_cnt = 0;
                bl_cnt = 0;
            end
            if (fs_a) begin
                if (have_prev) ichk("a_frame_period", per_cnt, AF);
                per_cnt   = 0;
                have_prev = 1'b1;
            end
            if (h == 0) line_hs = 0;
            line_hs += hsync_a ? 0 : 1;
            if (h == AHT - 1) ichk("a_hsync_width", line_hs, AHS);
            per_cnt++;
            vs_cnt += vsync_a ? 0 : 1;
            bl_cnt += blank_a ? 0 : 1;
        end
    endtask

    task automatic drive_b();
        int fb;
        fb = (e >= 2) ? (e - 2) / BF : 0;
        if (fb >= 78 && fb <= 81) pat_b = 2'd2;
        else if ($urandom_range(0, 31) == 0)
            pat_b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
    endtask

    initial begin
        int p;
        repeat (5) cycle();
        reset_n = 1'b1;
        while (e < 2 + 2 * AF + 20 * AHT + 300) begin
            p = e - 2;
            if (p >= 0 && p / AF == 0 && p >= 20 * AHT) pat_a = 2'd1;
            if (p >= 0 && p / AF == 2 && $urandom_range(0, 255) == 0) pat_a = 2'($urandom_range(0, 3));
            drive_b();
            cycle();
        end
        // Pulse reset mid-frame at (300,20); outputs must drop immediately
        reset_n = 1'b0;
        e = 0;
        line_hs = 0;
        vs_cnt = 0;
        bl_cnt = 0;
        per_cnt = 0;
        have_prev = 1'b0;
        #1;
        chk("a_async_reset", oa, model(AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB, 0, 2'd0));
        chk("b_async_reset", ob, model(BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB, 0, 2'd0));
        cycle();
        reset_n = 1'b1;
        repeat (3000) begin
            if ($urandom_range(0, 127) == 0) pat_a = 2'($urandom_range(0, 3));
            drive_b();
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
